// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and next-fetch-address resolution at the head of IF.
// Sources: sequential fetch, decode-stage branch/J/JR redirects (one delay slot),
// exception entry and ERET return. A pending-redirect buffer holds a redirect
// that arrives while fetch is held.
// Optional feature: define ADDR_CHECK_EN to register a fetch-address error
// flag (adel) alongside pc; when undefined adel is tied to 0.
module pc_sequencer #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [PC_W-1:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [PC_W-1:0] IMEM_HI    = 32'h0000_4FFC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_hold,
  input  logic            br_taken,
  input  logic            j_en,
  input  logic            jr_en,
  input  logic [PC_W-1:0] d_pc4,
  input  logic [15:0]     imm16,
  input  logic [25:0]     instr_index,
  input  logic [PC_W-1:0] jr_target,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc4,
  output logic            redirect_pending,
  output logic            adel
);

  localparam int unsigned SEXT_W = PC_W - 18;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pend_state_e;

  // Parameter sanity: jump target needs 28 low bits, legal window must be ordered.
  if (PC_W < 28 || IMEM_LO > IMEM_HI) begin : g_bad_cfg
    $error("pc_sequencer: PC_W must be >= 28 and IMEM_LO <= IMEM_HI");
  end

  pend_state_e     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic            adel_q, adel_d;

  logic [PC_W-1:0] br_tgt, j_tgt, eret_tgt, redir_tgt;
  logic            redir;
  logic            pc_upd;

  // Redirect target arithmetic, all modulo 2^PC_W.
  always_comb begin
    br_tgt    = d_pc4 + {{SEXT_W{imm16[15]}}, imm16, 2'b00};
    j_tgt     = (d_pc4 & ~PC_W'(28'hFFF_FFFF)) | PC_W'({instr_index, 2'b00});
    eret_tgt  = epc & ~PC_W'(2'b11);
    redir     = br_taken | j_en | jr_en;
    if (jr_en)     redir_tgt = jr_target;
    else if (j_en) redir_tgt = j_tgt;
    else           redir_tgt = br_tgt;
  end

  // Next-pc priority and pending-redirect state machine.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    pc_upd     = 1'b1;
    if (exc_req) begin
      pc_d    = EXC_VECTOR;
      state_d = ST_IDLE;
    end else if (eret_req) begin
      pc_d    = eret_tgt;
      state_d = ST_IDLE;
    end else if (stall) begin
      pc_upd = 1'b0;
    end else if (fetch_hold) begin
      pc_upd = 1'b0;
      if (redir) begin
        state_d    = ST_PEND;
        pend_tgt_d = redir_tgt;
      end
    end else if (state_q == ST_PEND) begin
      pc_d    = pend_tgt_q;
      state_d = ST_IDLE;
    end else if (redir) begin
      pc_d = redir_tgt;
    end else begin
      pc_d = pc_q + PC_W'(4);
    end
  end

  // Fetch-address error flag, refreshed only when pc is loaded.
  always_comb begin
    adel_d = adel_q;
`ifdef ADDR_CHECK_EN
    if (pc_upd) begin
      adel_d = (pc_d[1:0] != 2'b00) || (pc_d < IMEM_LO) || (pc_d > IMEM_HI);
    end
`else
    adel_d = 1'b0;
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_IDLE;
      pend_tgt_q <= '0;
      adel_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      adel_q     <= adel_d;
    end
  end

  assign pc               = pc_q;
  assign pc4              = pc_q + PC_W'(4);
  assign redirect_pending = (state_q == ST_PEND);
  assign adel             = adel_q;

endmodule
